// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract scheduler: FSM encodings and default sizes.
package addsub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEF_W     = 5;
  localparam int DEF_N_REQ = 4;

endpackage

// File: rtl/addsub_unit.sv
// W-bit ripple add/subtract unit: s = a + (b ^ {W{sub}}) + cin, with carry and signed overflow.
module addsub_unit #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ov
);

  logic [W-1:0] b_eff;
  logic [W:0]   c;

  assign b_eff = b ^ {W{sub}};
  assign c[0]  = cin;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      full_adder u_fa (
        .a  (a[gi]),
        .b  (b_eff[gi]),
        .ci (c[gi]),
        .s  (s[gi]),
        .co (c[gi+1])
      );
    end
  endgenerate

  assign cout = c[W];
  // Overflow when both effective operands share a sign that the sum does not.
  assign ov   = (a[W-1] == b_eff[W-1]) && (s[W-1] != a[W-1]);

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the ripple datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/addsub_scheduler.sv
// Round-robin arbiter time-sharing one ripple add/subtract unit among N_REQ requesters.
module addsub_scheduler
  import addsub_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] op_a,
  input  logic [N_REQ*W-1:0] op_b,
  input  logic [N_REQ-1:0]   op_sub,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic               done,
  output logic [W-1:0]       result,
  output logic               cout,
  output logic               ov_flag
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state_reg;
  logic [PW-1:0]    ptr_reg;
  logic [PW-1:0]    idx_reg;
  logic [N_REQ-1:0] gnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic             sub_reg;
  logic [W-1:0]     result_reg;
  logic             cout_reg;
  logic             ov_reg;

  logic [PW-1:0]    pick;
  logic [W-1:0]     sum_s;
  logic             sum_cout;
  logic             sum_ov;

  // First set request searching upward from ptr+1 with wrap; descending loop lets the
  // nearest candidate overwrite farther ones.
  function automatic logic [PW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [PW-1:0]    p);
    logic [PW-1:0] sel;
    int            idx;
    sel = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(p) + k) % N_REQ;
      if (r[idx]) sel = PW'(idx);
    end
    return sel;
  endfunction

  always_comb begin
    pick = rr_pick(req, ptr_reg);
  end

  addsub_unit #(.W(W)) u_unit (
    .a    (a_reg),
    .b    (b_reg),
    .sub  (sub_reg),
    .cin  (sub_reg),
    .s    (sum_s),
    .cout (sum_cout),
    .ov   (sum_ov)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      ptr_reg    <= PW'(N_REQ - 1);
      idx_reg    <= '0;
      gnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      sub_reg    <= 1'b0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
      ov_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (|req) begin
            idx_reg   <= pick;
            a_reg     <= op_a[pick*W +: W];
            b_reg     <= op_b[pick*W +: W];
            sub_reg   <= op_sub[pick];
            gnt_reg   <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
            busy_reg  <= 1'b1;
            state_reg <= S_EXEC;
          end
        end
        S_EXEC: begin
          result_reg <= sum_s;
          cout_reg   <= sum_cout;
          ov_reg     <= sum_ov;
          ptr_reg    <= idx_reg;
          done_reg   <= 1'b1;
          state_reg  <= S_DONE;
        end
        S_DONE: begin
          done_reg  <= 1'b0;
          gnt_reg   <= '0;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          gnt_reg   <= '0;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt     = gnt_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign result  = result_reg;
  assign cout    = cout_reg;
  assign ov_flag = ov_reg;

endmodule

// File: tb/tb_addsub_scheduler.sv
// Randomized and directed bench for addsub_scheduler against an arithmetic reference model.
module tb_addsub_scheduler;

  localparam int W = 5;
  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] op_a;
  logic [N*W-1:0] op_b;
  logic [N-1:0]   op_sub;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           done;
  logic [W-1:0]   result;
  logic           cout;
  logic           ov_flag;

  int n_checks = 0;
  int n_errors = 0;
  int model_ptr = N - 1;

  addsub_scheduler #(.W(W), .N_REQ(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .op_a    (op_a),
    .op_b    (op_b),
    .op_sub  (op_sub),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .cout    (cout),
    .ov_flag (ov_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Round-robin: the first requester after the last served one, wrapping around.
  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Returns {ov, cout, result} from plain unsigned/signed integer arithmetic.
  function automatic logic [W+1:0] model_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sub);
    int ua, ub, sa, sb, ur, sr;
    logic c, o;
    logic [W-1:0] r;
    ua = int'(a);
    ub = int'(b);
    sa = a[W-1] ? ua - (1 << W) : ua;
    sb = b[W-1] ? ub - (1 << W) : ub;
    if (sub) begin
      ur = ua - ub;
      sr = sa - sb;
      c  = (ua >= ub);
    end else begin
      ur = ua + ub;
      sr = sa + sb;
      c  = (ur >= (1 << W));
    end
    o = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    r = W'(ur & ((1 << W) - 1));
    return {o, c, r};
  endfunction

  // Called at a negedge with the DUT idle; runs one grant/exec/done sequence.
  task automatic do_op(input logic [N-1:0] r, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                       input logic [N-1:0] s, input bit scramble, input bit drop_req);
    int idx;
    logic [N-1:0] exp_gnt;
    logic [W+1:0] exp;
    req = r; op_a = a; op_b = b; op_sub = s;
    idx = model_pick(r, model_ptr);
    exp_gnt = '0;
    if (idx >= 0) exp_gnt[idx] = 1'b1;
    exp = (idx >= 0) ? model_alu(a[idx*W +: W], b[idx*W +: W], s[idx]) : '0;
    @(negedge clk);
    chk("gnt_exec", 32'(gnt), 32'(exp_gnt));
    chk("busy_exec", 32'(busy), 32'd1);
    chk("done_exec", 32'(done), 32'd0);
    if (scramble) begin
      op_a = {$urandom, $urandom};
      op_b = {$urandom, $urandom};
      op_sub = N'($urandom);
    end
    if (drop_req) req = '0;
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("gnt_done", 32'(gnt), 32'(exp_gnt));
    chk("result", 32'(result), 32'(exp[W-1:0]));
    chk("cout", 32'(cout), 32'(exp[W]));
    chk("ov_flag", 32'(ov_flag), 32'(exp[W+1]));
    @(negedge clk);
    chk("done_clear", 32'(done), 32'd0);
    chk("busy_clear", 32'(busy), 32'd0);
    chk("gnt_clear", 32'(gnt), 32'd0);
    $display("op req=%b gnt_exp=%b res=%0d cout=%0b ov=%0b", r, exp_gnt, result, cout, ov_flag);
    if (idx >= 0) model_ptr = idx;
  endtask

  function automatic logic [N*W-1:0] put(input int i, input logic [W-1:0] v);
    logic [N*W-1:0] t;
    t = '0;
    t[i*W +: W] = v;
    return t;
  endfunction

  initial begin
    logic [N-1:0] rr;
    logic [N*W-1:0] ra, rb;
    req = '0; op_a = '0; op_b = '0; op_sub = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ov", 32'(ov_flag), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic cases
    do_op(4'b0001, put(0, 5'd3), put(0, 5'd5), 4'b0000, 1'b0, 1'b0);
    chk("add_3_5", 32'(result), 32'd8);
    do_op(4'b0100, put(2, 5'd3), put(2, 5'd5), 4'b0100, 1'b0, 1'b0);
    chk("sub_3_5", 32'(result), 32'h1e);
    chk("sub_3_5_cout", 32'(cout), 32'd0);
    do_op(4'b0100, put(2, 5'd5), put(2, 5'd3), 4'b0100, 1'b0, 1'b0);
    chk("sub_5_3", 32'(result), 32'd2);
    chk("sub_5_3_cout", 32'(cout), 32'd1);
    do_op(4'b0001, put(0, 5'd15), put(0, 5'd1), 4'b0000, 1'b0, 1'b0);
    chk("add_ovf", 32'(ov_flag), 32'd1);
    chk("add_ovf_res", 32'(result), 32'd16);
    do_op(4'b0001, put(0, 5'd16), put(0, 5'd1), 4'b0001, 1'b0, 1'b0);
    chk("sub_ovf", 32'(ov_flag), 32'd1);
    chk("sub_ovf_res", 32'(result), 32'd15);
    chk("sub_ovf_cout", 32'(cout), 32'd1);

    // All requesting continuously: grants rotate 1,2,3,0,1 from ptr=0
    for (int k = 0; k < 5; k++) begin
      do_op(4'b1111, {$urandom, $urandom}, {$urandom, $urandom}, N'($urandom), 1'b0, 1'b0);
      chk("rr_order", 32'(model_ptr), 32'((1 + k) % N));
    end

    // Operand/request changes during EXEC must not disturb the latched operation
    do_op(4'b0010, put(1, 5'd7), put(1, 5'd9), 4'b0000, 1'b1, 1'b1);
    chk("latched_res", 32'(result), 32'd16);

    // Reset during EXEC discards the operation
    req = 4'b0100; op_a = put(2, 5'd1); op_b = put(2, 5'd1); op_sub = '0;
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst_done", 32'(done), 32'd0);
    end
    req = '0;
    rst_n = 1'b1;
    model_ptr = N - 1;
    @(negedge clk);
    do_op(4'b1001, put(0, 5'd2) | put(3, 5'd4), put(0, 5'd2) | put(3, 5'd4), 4'b0000, 1'b0, 1'b0);
    chk("post_rst_res", 32'(result), 32'd4);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      rr = N'($urandom_range(1, (1 << N) - 1));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      do_op(rr, ra, rb, N'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
